// File: rtl/blinky_pkg.sv
// Shared types and constants for the blinky speed path: the speed index type
// consumed by the LUT stage, the repeat FSM encoding, debug visibility and
// the saturating index update.
package blinky_pkg;

    localparam int SPEED_IDX_W   = 4;
    localparam int SPEED_IDX_MAX = 15;

    // Index that selects an entry of the LUT blinky stage.
    typedef logic [SPEED_IDX_W-1:0] speed_idx_t;

    // Step-request FSM: waiting for a press, waiting out the repeat delay,
    // and auto-repeating.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    // Default timing at 100 MHz: 10 ms debounce, 0.5 s repeat delay,
    // 0.2 s repeat period.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 32'd50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 32'd20_000_000;
    localparam speed_idx_t  DEF_INIT_INDEX      = 4'd3;

    // Internal state made visible on the bus so checkers can observe both
    // conditioners without hierarchical references.
    typedef struct packed {
        rpt_state_e up_state;
        rpt_state_e dn_state;
        logic       up_level;
        logic       dn_level;
    } ctrl_dbg_t;

    localparam logic [SPEED_IDX_W:0] IDX_ONE_W = (SPEED_IDX_W+1)'(1);
    localparam logic [SPEED_IDX_W:0] IDX_MAX_W = (SPEED_IDX_W+1)'(SPEED_IDX_MAX);

    // Saturating one-step update. The extra bit keeps 15+1 and 0-1 from
    // wrapping before the clamp is applied. Coincident up and down cancel.
    function automatic speed_idx_t sat_step(input speed_idx_t cur,
                                            input logic       up,
                                            input logic       dn);
        logic [SPEED_IDX_W:0] wide;
        wide = {1'b0, cur};
        if (up && !dn) begin
            wide = wide + IDX_ONE_W;
            if (wide > IDX_MAX_W) begin
                wide = IDX_MAX_W;
            end
        end else if (dn && !up) begin
            wide = wide - IDX_ONE_W;
            if (wide[SPEED_IDX_W]) begin
                wide = '0;
            end
        end
        return wide[SPEED_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/speed_index_ctrl_if.sv
// Bus between the push buttons and the speed index controller.
//
// Signal semantics (no valid/ready handshake is involved here):
//   btn_up / btn_dn : raw, asynchronous, bouncy button levels, active-high.
//   speed_idx       : registered index, always valid outside reset.
//   idx_changed     : one-cycle strobe, high exactly in the cycle in which
//                     speed_idx first shows its new value.
//   dbg             : live conditioner state, observation only.
interface speed_index_ctrl_if;
    import blinky_pkg::*;

    logic       btn_up;
    logic       btn_dn;
    speed_idx_t speed_idx;
    logic       idx_changed;
    ctrl_dbg_t  dbg;

    // Button side: drives the raw levels, watches the index.
    modport master (
        output btn_up,
        output btn_dn,
        input  speed_idx,
        input  idx_changed,
        input  dbg
    );

    // Controller side.
    modport slave (
        input  btn_up,
        input  btn_dn,
        output speed_idx,
        output idx_changed,
        output dbg
    );

endinterface

// File: rtl/btn_conditioner.sv
// One push button: 2-FF synchronizer, debounce to an accepted level, and a
// press / hold / auto-repeat FSM that emits single-cycle step pulses.
module btn_conditioner
    import blinky_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       step,
    output rpt_state_e state,
    output logic       level
);

    localparam logic [31:0] DB_LAST    = DEBOUNCE_CYCLES - 32'd1;
    localparam logic [31:0] DELAY_LAST = REPEAT_DELAY - 32'd1;
    localparam logic [31:0] PER_LAST   = REPEAT_PERIOD - 32'd1;

    logic        sync1_q;
    logic        sync2_q;
    logic        level_q;
    logic        level_d;
    logic [31:0] db_cnt_q;
    logic [31:0] db_cnt_d;
    rpt_state_e  state_q;
    rpt_state_e  state_d;
    logic [31:0] rpt_cnt_q;
    logic [31:0] rpt_cnt_d;
    logic        step_c;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last
    // one, and forget the run as soon as the synced level agrees again.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 32'd1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Step-request FSM: a step on the press, one after the repeat delay, then
    // one per repeat period; a release always wins and never steps.
    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        step_c    = 1'b0;
        case (state_q)
            IDLE: begin
                rpt_cnt_d = '0;
                if (level_q) begin
                    step_c  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!level_q) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == DELAY_LAST) begin
                    step_c    = 1'b1;
                    state_d   = REPEAT;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 32'd1;
                end
            end
            REPEAT: begin
                if (!level_q) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PER_LAST) begin
                    step_c    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    // FSM state and repeat counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign step  = step_c;
    assign state = state_q;
    assign level = level_q;

endmodule

// File: rtl/speed_index_ctrl.sv
// Debounced up/down speed selector. Two button conditioners produce step
// pulses; this level owns only the saturating index and its change strobe.
module speed_index_ctrl
    import blinky_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter speed_idx_t  INIT_INDEX      = DEF_INIT_INDEX
) (
    input  logic               clk,
    input  logic               rst,
    speed_index_ctrl_if.slave  bus
);

    logic       step_up;
    logic       step_dn;
    rpt_state_e up_state;
    rpt_state_e dn_state;
    logic       up_level;
    logic       dn_level;
    speed_idx_t idx_q;
    speed_idx_t idx_d;
    logic       chg_q;
    logic       chg_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_up),
        .step  (step_up),
        .state (up_state),
        .level (up_level)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_dn),
        .step  (step_dn),
        .state (dn_state),
        .level (dn_level)
    );

    // Next index and strobe: the strobe is raised only when the value really
    // moves, so cancelled or saturated steps stay silent.
    always_comb begin
        idx_d = sat_step(idx_q, step_up, step_dn);
        chg_d = (idx_d != idx_q);
    end

    // Index and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= INIT_INDEX;
            chg_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            chg_q <= chg_d;
        end
    end

    assign bus.speed_idx   = idx_q;
    assign bus.idx_changed = chg_q;
    assign bus.dbg         = '{up_state: up_state, dn_state: dn_state,
                               up_level: up_level, dn_level: dn_level};

endmodule
